picorv32_write_buffer: RTL

Posted-write buffer between the PicoRV32 native memory port and the FreeAHB adapter. Writes are acknowledged to the core as soon as they are queued and drained downstream in order. Reads are issued downstream only after all queued writes have drained, so ordering is preserved. Both sides use the PicoRV32 native valid/ready protocol; the downstream side feeds the adapter's `mem_*` inputs.

---
 rtl/picorv_wbuf_pkg.sv | 24 ++
 rtl/picorv_wbuf_fifo.sv | 64 ++++++
 rtl/picorv32_write_buffer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/picorv_wbuf_pkg.sv
// Shared types for the PicoRV32 posted-write buffer: downstream FSM states,
// the queued write entry layout and the byte-strobe width.
package picorv_wbuf_pkg;

  localparam int WSTRB_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DN_WR = 2'd1,
    DN_RD = 2'd2
  } dn_state_t;

  typedef struct packed {
    logic [31:0]        addr;
    logic [31:0]        wdata;
    logic [WSTRB_W-1:0] wstrb;
  } wbuf_entry_t;

  // A native-port request with any strobe bit set is a write.
  function automatic logic is_write(input logic [WSTRB_W-1:0] strb);
    return |strb;
  endfunction

endpackage

// File: rtl/picorv_wbuf_fifo.sv
// Synchronous DEPTH-entry FIFO of write entries for the posted-write buffer.
// DEPTH must be a power of two (>= 2) so the pointers wrap by natural overflow.
// Push is ignored when full and pop is ignored when empty; both may occur in
// the same cycle. The head entry is presented combinationally from storage.
module picorv_wbuf_fifo
  import picorv_wbuf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  wbuf_entry_t                push_entry,
  input  logic                       pop,
  output wbuf_entry_t                head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wbuf_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Entry storage: data only, never reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/picorv32_write_buffer.sv
// Posted-write buffer between the PicoRV32 native memory port and the FreeAHB
// adapter. Writes are acknowledged as soon as they are queued and drained
// downstream in order; reads go downstream only once every queued write has
// drained, so the core never observes a read overtaking an earlier write.
//
// Optional feature macro: PICORV_WBUF_INSTR_BYPASS_EN
//   When defined, a pending instruction fetch may be issued ahead of queued
//   writes. Data reads still wait for the drain. Software must fence before
//   executing freshly written code.
//
// DEPTH must be a power of two, minimum 2.
module picorv32_write_buffer
  import picorv_wbuf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               resetn,
  // core side
  input  logic               mem_valid,
  input  logic               mem_instr,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  input  logic [WSTRB_W-1:0] mem_wstrb,
  output logic               mem_ready,
  output logic [31:0]        mem_rdata,
  // downstream side (adapter mem_* inputs)
  output logic               dn_valid,
  output logic               dn_instr,
  output logic [31:0]        dn_addr,
  output logic [31:0]        dn_wdata,
  output logic [WSTRB_W-1:0] dn_wstrb,
  input  logic               dn_ready,
  input  logic [31:0]        dn_rdata,
  // status
  output logic               wbuf_empty
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  dn_state_t        state;
  wbuf_entry_t      head;
  wbuf_entry_t      push_entry;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             read_pending;
  logic             fetch_bypass;
  logic             rd_done;

  // A request is only considered while mem_ready is low, so the cycle that
  // acknowledges one request can never also accept or issue that request.
  assign push         = mem_valid && is_write(mem_wstrb) && !fifo_full && !mem_ready;
  assign read_pending = mem_valid && !is_write(mem_wstrb) && !mem_ready;
  assign pop          = (state == DN_WR) && dn_ready;
  assign rd_done      = (state == DN_RD) && dn_ready;

  assign push_entry.addr  = mem_addr;
  assign push_entry.wdata = mem_wdata;
  assign push_entry.wstrb = mem_wstrb;

`ifdef PICORV_WBUF_INSTR_BYPASS_EN
  // Fetches jump ahead of the drain; data reads still wait for it.
  assign fetch_bypass = read_pending && mem_instr;
`else
  assign fetch_bypass = 1'b0;
`endif

  // The head entry stays put until its downstream write completes, so the
  // popped entry is exactly the one that was on the dn_* bus.
  assign wbuf_empty = fifo_empty && (state != DN_WR);

  picorv_wbuf_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // Downstream FSM plus the registered core-side acknowledge and read data.
  // Every transaction returns to IDLE for at least one cycle, which keeps
  // dn_valid low between back-to-back downstream transfers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      dn_valid  <= 1'b0;
      dn_instr  <= 1'b0;
      dn_addr   <= '0;
      dn_wdata  <= '0;
      dn_wstrb  <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_ready <= push || rd_done;
      if (rd_done) begin
        mem_rdata <= dn_rdata;
      end

      case (state)
        IDLE: begin
          if (fetch_bypass) begin
            state    <= DN_RD;
            dn_valid <= 1'b1;
            dn_instr <= mem_instr;
            dn_addr  <= mem_addr;
            dn_wdata <= '0;
            dn_wstrb <= '0;
          end else if (fifo_count != '0) begin
            state    <= DN_WR;
            dn_valid <= 1'b1;
            dn_instr <= 1'b0;
            dn_addr  <= head.addr;
            dn_wdata <= head.wdata;
            dn_wstrb <= head.wstrb;
          end else if (read_pending && !push) begin
            state    <= DN_RD;
            dn_valid <= 1'b1;
            dn_instr <= mem_instr;
            dn_addr  <= mem_addr;
            dn_wdata <= '0;
            dn_wstrb <= '0;
          end
        end
        DN_WR: begin
          if (dn_ready) begin
            state    <= IDLE;
            dn_valid <= 1'b0;
          end
        end
        DN_RD: begin
          if (dn_ready) begin
            state    <= IDLE;
            dn_valid <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          dn_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
